// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    // Frame-tracking FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StDone
    } state_e;

    // Value of the leading R/W bit of a frame.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total frame length in bits: R/W flag + address field + data field.
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall detection on the
// synchronised level.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one extra flop holding the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target giving read/write access to a bank of control registers.
// Frame, MSB first: R/W (1 = write), address, data.
// A write commits on the chip-select rise; a read returns a snapshot taken when the
// address field completes.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       NUM_REGS    = 5,
    parameter int unsigned       ADDR_W      = 7,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_pulse_o,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic                         err_o
);

    localparam int unsigned       FrameW     = frame_w(ADDR_W, DATA_W);
    localparam int unsigned       CntW       = $clog2(FrameW + 2);
    localparam logic [CntW-1:0]   CntAddrEnd = CntW'(ADDR_W);  // count before last address bit
    localparam logic [CntW-1:0]   CntLast    = CntW'(FrameW - 1);
    localparam logic [CntW-1:0]   CntFull    = CntW'(FrameW);
    localparam logic [CntW-1:0]   CntMax     = CntW'(FrameW + 1);
    localparam logic [ADDR_W:0]   NumRegsW   = (ADDR_W + 1)'(NUM_REGS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NumRegsW;
    endfunction

    // Synchronised pins.
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s, copi_rise, copi_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .q_o    (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (ncs),
        .q_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (copi),
        .q_o    (copi_s),
        .rise_o (copi_rise),
        .fall_o (copi_fall)
    );

    assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FrameW-1:0]   shift_q, shift_d, shift_nxt;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                rd_armed_q, rd_armed_d;
    logic                oe_q, oe_d, cipo_q, cipo_d;
    logic                wr_pend_q, wr_pend_d, err_pend_q, err_pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                wr_pulse_q, err_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                sample, decide, frame_ok, frame_rw, hdr_rw;
    logic [ADDR_W-1:0]   frame_addr, hdr_addr;
    logic [DATA_W-1:0]   frame_data, rd_word;

    // Bits are only taken inside a frame that started with a seen ncs fall; an ncs rise
    // in the same clk leaves ncs_s high, so the edge is ignored.
    assign sample    = sclk_rise & ~ncs_s & (state_q != StIdle);
    assign decide    = ncs_rise & (state_q != StIdle);
    assign shift_nxt = {shift_q[FrameW-2:0], copi_s};

    // Header as it will look once the current bit is shifted in.
    assign hdr_rw     = shift_nxt[ADDR_W];
    assign hdr_addr   = shift_nxt[ADDR_W-1:0];

    // Fields of a complete frame, valid when cnt_q == CntFull.
    assign frame_rw   = shift_q[FrameW-1];
    assign frame_addr = shift_q[FrameW-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign frame_ok   = (cnt_q == CntFull) && addr_ok(frame_addr);

    // Read-back mux; an out-of-range address matches nothing and yields zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr == ADDR_W'(k)) rd_word = regs_q[k];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state: track which field of the frame is being received.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ncs_fall) state_d = StCmd;
            StCmd: begin
                if (sample && cnt_q == CntAddrEnd) begin
                    state_d = (hdr_rw == RW_WRITE) ? StWdata : StRdata;
                end
            end
            StWdata,
            StRdata: if (sample && cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (ncs_rise) state_d = StIdle;
    end

    // Datapath next state: shift in, read-out shifting and commit/discard decision.
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        out_d       = out_q;
        rd_armed_d  = rd_armed_q;
        oe_d        = oe_q;
        cipo_d      = cipo_q;
        wr_pend_d   = 1'b0;
        err_pend_d  = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;

        if (ncs_fall) begin
            cnt_d      = '0;
            shift_d    = '0;
            out_d      = '0;
            rd_armed_d = 1'b0;
            oe_d       = 1'b0;
            cipo_d     = 1'b0;
        end else if (sample) begin
            shift_d = shift_nxt;
            if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
            if (state_q == StCmd && cnt_q == CntAddrEnd && hdr_rw == RW_READ) begin
                out_d      = rd_word;
                rd_armed_d = 1'b1;
            end
        end else if (sclk_fall && rd_armed_q && !ncs_s) begin
            // Zeros shift in behind the data, so cipo idles low after DATA_W bits.
            oe_d   = 1'b1;
            cipo_d = out_q[DATA_W-1];
            out_d  = {out_q[DATA_W-2:0], 1'b0};
        end

        if (ncs_s) begin
            oe_d       = 1'b0;
            cipo_d     = 1'b0;
            rd_armed_d = 1'b0;
        end

        if (decide) begin
            if (!frame_ok) begin
                err_pend_d = 1'b1;
            end else if (frame_rw == RW_WRITE) begin
                wr_pend_d   = 1'b1;
                pend_addr_d = frame_addr;
                pend_data_d = frame_data;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            out_q       <= '0;
            rd_armed_q  <= 1'b0;
            oe_q        <= 1'b0;
            cipo_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            rd_armed_q  <= rd_armed_d;
            oe_q        <= oe_d;
            cipo_q      <= cipo_d;
            wr_pend_q   <= wr_pend_d;
            err_pend_q  <= err_pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Register bank and the one-clk write/error strobes, one clk after the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
            wr_pulse_q <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_pulse_q <= wr_pend_q;
            err_q      <= err_pend_q;
            if (wr_pend_q) begin
                wr_addr_q <= pend_addr_q;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (pend_addr_q == ADDR_W'(k)) regs_q[k] <= pend_data_q;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign cipo       = cipo_q;
    assign cipo_oe    = oe_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_addr_o  = wr_addr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: table of single frames plus hand-written
// sequences for commit latency, read-back, reset mid-frame and back-to-back frames.
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

    localparam int unsigned NumRegs    = 5;
    localparam int unsigned AddrW      = 7;
    localparam int unsigned DataW      = 8;
    localparam int unsigned SyncStages = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       sclk = 1'b0;
    logic                       copi = 1'b0;
    logic                       ncs = 1'b1;
    logic                       cipo, cipo_oe, wr_pulse_o, err_o;
    logic [NumRegs*DataW-1:0]   regs_o;
    logic [AddrW-1:0]           wr_addr_o;

    always #5 clk = ~clk;

    spi_regfile_peripheral #(
        .NUM_REGS    (NumRegs),
        .ADDR_W      (AddrW),
        .DATA_W      (DataW),
        .SYNC_STAGES (SyncStages),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .copi       (copi),
        .ncs        (ncs),
        .cipo       (cipo),
        .cipo_oe    (cipo_oe),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_addr_o  (wr_addr_o),
        .err_o      (err_o)
    );

    int passed = 0;
    int total  = 0;
    int wr_seen = 0;
    int err_seen = 0;

    logic [DataW-1:0] exp_regs [NumRegs];
    logic [15:0]      rx_cipo, rx_oe;
    logic             post_cipo, post_oe;

    // Count strobe cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_pulse_o === 1'b1) wr_seen++;
        if (err_o === 1'b1)      err_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             passed++;
    endtask

    task automatic check_regs(input string name);
        logic [NumRegs*DataW-1:0] ef;
        for (int k = 0; k < NumRegs; k++) ef[k*DataW +: DataW] = exp_regs[k];
        check(name, 64'(regs_o), 64'(ef));
    endtask

    // Drop ncs and clock out nbits of word MSB first at sclk = clk/8; ncs stays low.
    task automatic frame_bits(input logic [31:0] word, input int nbits);
        ncs = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            copi = word[nbits-1-i];
            #40;
            if (i < 16) begin
                rx_cipo[i] = cipo;
                rx_oe[i]   = cipo_oe;
            end
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        #40;
        post_cipo = cipo;
        post_oe   = cipo_oe;
    endtask

    task automatic end_frame(input int gap);
        ncs = 1'b1;
        #(gap);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        logic       exp_wr;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int         w0, e0;
        logic [15:0] w16;
        logic [31:0] word;
        logic [7:0]  got;

        vecs[0] = '{1'b1, 7'd4,  8'h5A, 16, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 7'd5,  8'hAA, 16, 1'b0, 1'b1};  // first invalid address
        vecs[2] = '{1'b1, 7'd1,  8'h11, 15, 1'b0, 1'b1};  // short frame
        vecs[3] = '{1'b1, 7'd1,  8'h22, 17, 1'b0, 1'b1};  // overlong frame
        vecs[4] = '{1'b1, 7'd1,  8'h33, 16, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 7'd2,  8'h3C, 16, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 7'd3,  8'h00, 16, 1'b0, 1'b0};  // valid read
        vecs[7] = '{1'b1, 7'h7F, 8'h01, 16, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 7'd6,  8'h00, 16, 1'b0, 1'b1};  // read, invalid address
        vecs[9] = '{1'b1, 7'd3,  8'hC3, 16, 1'b1, 1'b0};

        for (int k = 0; k < NumRegs; k++) exp_regs[k] = 8'h00;

        // Reset state; the first ncs rise seen by the synchroniser must not flag an error.
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        check_regs("reset regs");
        check("reset cipo_oe", 64'(cipo_oe), 64'd0);
        check("reset cipo", 64'(cipo), 64'd0);
        check("reset wr_pulse", 64'(wr_pulse_o), 64'd0);
        check("reset wr_addr", 64'(wr_addr_o), 64'd0);
        check("reset no err", 64'(err_seen), 64'd0);

        // Commit latency: reg0 updates SYNC_STAGES+2 clk after ncs rises.
        e0 = err_seen;
        frame_bits({16'h0, 1'b1, 7'd0, 8'hF0}, 16);
        @(posedge clk);
        #1 ncs = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                check("lat reg0 before", 64'(regs_o[7:0]), 64'h00);
                check("lat pulse before", 64'(wr_pulse_o), 64'd0);
            end
            if (k == 4) begin
                check("lat reg0 after", 64'(regs_o[7:0]), 64'hF0);
                check("lat pulse", 64'(wr_pulse_o), 64'd1);
                check("lat wr_addr", 64'(wr_addr_o), 64'd0);
            end
            if (k == 5) check("lat pulse width", 64'(wr_pulse_o), 64'd0);
        end
        exp_regs[0] = 8'hF0;
        #100;
        check("lat no err", 64'(err_seen - e0), 64'd0);
        @(posedge clk);
        #3;

        // Single-frame table.
        for (int v = 0; v < 10; v++) begin
            w16  = {vecs[v].rw, vecs[v].addr, vecs[v].data};
            word = {16'h0, w16};
            w0 = wr_seen;
            e0 = err_seen;
            if (vecs[v].nbits < 16)      frame_bits(word >> (16 - vecs[v].nbits), vecs[v].nbits);
            else if (vecs[v].nbits > 16) frame_bits(word << (vecs[v].nbits - 16), vecs[v].nbits);
            else                         frame_bits(word, 16);
            end_frame(100);
            if (vecs[v].exp_wr) exp_regs[int'(vecs[v].addr)] = vecs[v].data;
            check($sformatf("vec%0d wr pulses", v), 64'(wr_seen - w0), 64'(vecs[v].exp_wr));
            check($sformatf("vec%0d err pulses", v), 64'(err_seen - e0), 64'(vecs[v].exp_err));
            check_regs($sformatf("vec%0d regs", v));
            if (vecs[v].exp_wr) check($sformatf("vec%0d wr_addr", v), 64'(wr_addr_o),
                                      64'(vecs[v].addr));
        end

        // Read back reg2 (0x3C): cipo must present 0,0,1,1,1,1,0,0.
        w0 = wr_seen;
        e0 = err_seen;
        frame_bits({16'h0, 1'b0, 7'd2, 8'h00}, 16);
        for (int j = 0; j < 8; j++) got[7-j] = rx_cipo[8+j];
        check("read data", 64'(got), 64'h3C);
        check("read oe window", 64'(rx_oe), 64'hFF00);
        check("read cipo after data", 64'(post_cipo), 64'd0);
        check("read oe before ncs rise", 64'(post_oe), 64'd1);
        end_frame(100);
        check("read oe after ncs", 64'(cipo_oe), 64'd0);
        check("read cipo after ncs", 64'(cipo), 64'd0);
        check("read no write", 64'(wr_seen - w0), 64'd0);
        check("read no err", 64'(err_seen - e0), 64'd0);

        // Reset after 10 bits of a write; the partial frame must be discarded.
        w0 = wr_seen;
        frame_bits({16'h0, 1'b1, 7'd1, 8'h99} >> 6, 10);
        rst_n = 1'b0;
        #20;
        for (int k = 0; k < NumRegs; k++) exp_regs[k] = 8'h00;
        check_regs("rst mid regs");
        check("rst mid cipo_oe", 64'(cipo_oe), 64'd0);
        rst_n = 1'b1;
        #20;
        end_frame(100);
        check_regs("rst partial dropped");
        check("rst no write", 64'(wr_seen - w0), 64'd0);
        frame_bits({16'h0, 1'b1, 7'd1, 8'h99}, 16);
        end_frame(100);
        exp_regs[1] = 8'h99;
        check_regs("post rst write");
        check("post rst pulse", 64'(wr_seen - w0), 64'd1);

        // Back-to-back writes with minimal ncs-high gap at random sclk/clk phase.
        w0 = wr_seen;
        e0 = err_seen;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #($urandom_range(1, 9));
            for (int k = 0; k < NumRegs; k++) begin
                got = 8'(8'hA0 + 16 * r + k);
                frame_bits({16'h0, 1'b1, 7'(k), got}, 16);
                end_frame(50);
                exp_regs[k] = got;
            end
        end
        #100;
        check_regs("b2b regs");
        check("b2b pulses", 64'(wr_seen - w0), 64'd15);
        check("b2b no err", 64'(err_seen - e0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
